multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of independent key channels (1..32).
REQ-002 The block SHALL have parameter CNT_W, default 24, meaning the width of the stability and hold counters.
REQ-003 The block SHALL have parameter STABLE_CNT, default 24'd10_000_000, meaning the stability threshold in clk cycles (>=1, < 2^CNT_W).
REQ-004 The block SHALL have parameter LONG_CNT, default 24'd16_000_000, meaning the long-press threshold in clk cycles (>=1, < 2^CNT_W).
REQ-005 The block SHALL have parameter ACTIVE_HIGH, default 1, meaning 1 = pressed key reads 1, 0 = pressed key reads 0.
REQ-006 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port key_i, input, N_CH bits, raw asynchronous key levels, one bit per channel.
REQ-009 The block SHALL have port key_o, output, N_CH bits, debounced level per channel.
REQ-010 The block SHALL have port press_o, output, N_CH bits, one-cycle pulse on debounced press.
REQ-011 The block SHALL have port release_o, output, N_CH bits, one-cycle pulse on debounced release.
REQ-012 The block SHALL have port long_o, output, N_CH bits, one-cycle pulse when a press has been held LONG_CNT cycles.
REQ-013 The block SHALL have port any_event_o, output, 1 bit, OR of all press_o, release_o and long_o bits in the same cycle.

Function
REQ-014 Each channel SHALL pass key_i through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-015 Each channel SHALL hold a candidate level cand and a stability counter cnt (CNT_W bits).
REQ-016 If sync2 != cand, the channel SHALL load cand <= sync2 and cnt <= 0 on that edge.
REQ-017 Else if cnt == STABLE_CNT, the channel SHALL load key_o <= cand and hold cnt (saturate, no wrap).
REQ-018 Else the channel SHALL increment cnt by 1.
REQ-019 An input change held stable SHALL therefore appear on key_o exactly STABLE_CNT+4 rising edges after the first edge that samples the new key_i level.
REQ-020 A glitch shorter than STABLE_CNT+1 cycles at sync2 SHALL NOT change key_o.
REQ-021 press_o[i] SHALL be 1 for exactly the one cycle after key_o[i] changes from idle to active level (active = ACTIVE_HIGH).
REQ-022 release_o[i] SHALL be 1 for exactly the one cycle after key_o[i] changes from active to idle level.
REQ-023 Each channel SHALL hold a hold counter hcnt, cleared to 0 whenever key_o[i] is idle, incremented while key_o[i] is active and a long-press has not yet fired.
REQ-024 long_o[i] SHALL pulse for one cycle on the edge where hcnt reaches LONG_CNT; it SHALL fire at most once per press, and hcnt SHALL NOT wrap.
REQ-025 A release in the same cycle hcnt would reach LONG_CNT SHALL produce release_o only, no long_o.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-027 any_event_o SHALL be combinational from the registered pulse outputs (no extra latency).
REQ-028 Counter comparisons SHALL use full CNT_W width; thresholds SHALL be zero-extended to CNT_W.

Reset
REQ-029 While reset_n = 0, sync1, sync2, cand and key_o SHALL be the idle level (~ACTIVE_HIGH) for every channel.
REQ-030 While reset_n = 0, cnt, hcnt, press_o, release_o, long_o and any_event_o SHALL be 0.
REQ-031 Assertion of reset_n mid-count or mid-press SHALL abort all channels immediately, with no pulse emitted on release of reset.
REQ-032 A key held active through reset deassertion SHALL produce press_o after STABLE_CNT+4 edges, like a fresh press.

Verification (N_CH=4, STABLE_CNT=4, LONG_CNT=10, ACTIVE_HIGH=1)
REQ-033 Clean press: key_i[0] 0->1 and held -> key_o[0]=1 and press_o[0]=1 for one cycle, 8 edges after first sampling; other bits stay 0.
REQ-034 Bounce: key_i[1] toggles with 3-cycle high pulses, then holds 1 -> no press_o until 8 edges after the final rise; exactly one press_o.
REQ-035 Long press: key_i[2] held 1 for 30 cycles -> one press_o, long_o 10 edges after key_o rises, no second long_o, release_o 8 edges after drop.
REQ-036 Simultaneous: key_i = 4'b1111 in one cycle -> press_o = 4'b1111 and any_event_o = 1 in the same single cycle.
REQ-037 Reset mid-operation: reset_n pulsed low during a count -> all outputs 0 immediately, no pulse after reset_n rises with key_i = 0.
REQ-038 Short release: key_i[3] drops for 2 cycles during a held press -> no release_o, long_o timing unaffected.

Source files
------------

// File: rtl/multi_debounce.sv
// multi_debounce: N_CH independent key debouncers with press/release/long-press pulses.
// Ports: clk, reset_n (async active-low), key_i raw keys, key_o debounced levels,
//        press_o/release_o/long_o one-cycle pulses per channel, any_event_o OR of all pulses.
module multi_debounce #(
    parameter int unsigned      N_CH        = 4,
    parameter int unsigned      CNT_W       = 24,
    parameter logic [CNT_W-1:0] STABLE_CNT  = 24'd10_000_000,
    parameter logic [CNT_W-1:0] LONG_CNT    = 24'd16_000_000,
    parameter bit               ACTIVE_HIGH = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] key_i,
    output logic [N_CH-1:0] key_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o,
    output logic            any_event_o
);

    localparam logic             IDLE    = ~ACTIVE_HIGH;
    localparam logic [CNT_W-1:0] LONG_M1 = LONG_CNT - 1'b1;

    logic [N_CH-1:0]  r_sync1;
    logic [N_CH-1:0]  r_sync2;
    logic [N_CH-1:0]  r_cand;
    logic [N_CH-1:0]  r_key;
    logic [N_CH-1:0]  r_press;
    logic [N_CH-1:0]  r_rel;
    logic [N_CH-1:0]  r_long;
    logic [CNT_W-1:0] r_cnt  [N_CH];
    logic [CNT_W-1:0] r_hcnt [N_CH];

    logic [N_CH-1:0]  w_key_nxt;
    logic [N_CH-1:0]  w_act_cur;
    logic [N_CH-1:0]  w_act_nxt;

    // Debounced level for the coming edge: commit the candidate once it has
    // been stable for STABLE_CNT counts.
    always_comb begin
        w_key_nxt = r_key;
        for (int i = 0; i < N_CH; i++) begin
            if (r_sync2[i] == r_cand[i] && r_cnt[i] == STABLE_CNT)
                w_key_nxt[i] = r_cand[i];
        end
    end

    // Polarity-normalised views: 1 means "pressed".
    assign w_act_cur = ACTIVE_HIGH ? r_key     : ~r_key;
    assign w_act_nxt = ACTIVE_HIGH ? w_key_nxt : ~w_key_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= {N_CH{IDLE}};
            r_sync2 <= {N_CH{IDLE}};
            r_cand  <= {N_CH{IDLE}};
            r_key   <= {N_CH{IDLE}};
            r_press <= '0;
            r_rel   <= '0;
            r_long  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i]  <= '0;
                r_hcnt[i] <= '0;
            end
        end else begin
            r_sync1 <= key_i;
            r_sync2 <= r_sync1;
            r_key   <= w_key_nxt;
            r_press <= w_act_nxt & ~w_act_cur;
            r_rel   <= w_act_cur & ~w_act_nxt;
            for (int i = 0; i < N_CH; i++) begin
                if (r_sync2[i] != r_cand[i]) begin
                    r_cand[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else if (r_cnt[i] != STABLE_CNT) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end

                // Hold counter stops at LONG_CNT, which also marks the
                // long-press as already fired for this press. A release on
                // the same edge clears it first, so no long pulse then.
                r_long[i] <= 1'b0;
                if (!w_act_nxt[i]) begin
                    r_hcnt[i] <= '0;
                end else if (w_act_cur[i] && r_hcnt[i] != LONG_CNT) begin
                    r_hcnt[i] <= r_hcnt[i] + 1'b1;
                    r_long[i] <= (r_hcnt[i] == LONG_M1);
                end
            end
        end
    end

    assign key_o       = r_key;
    assign press_o     = r_press;
    assign release_o   = r_rel;
    assign long_o      = r_long;
    assign any_event_o = |(r_press | r_rel | r_long);

endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: directed self-checking bench for multi_debounce
// (N_CH=4, STABLE_CNT=4, LONG_CNT=10, ACTIVE_HIGH=1).
module tb_multi_debounce;

    logic       clk;
    logic       reset_n;
    logic [3:0] key_i;
    logic [3:0] key_o;
    logic [3:0] press_o;
    logic [3:0] release_o;
    logic [3:0] long_o;
    logic       any_event_o;

    int total;
    int bad;

    multi_debounce #(
        .N_CH       (4),
        .CNT_W      (24),
        .STABLE_CNT (24'd4),
        .LONG_CNT   (24'd10),
        .ACTIVE_HIGH(1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_i      (key_i),
        .key_o      (key_o),
        .press_o    (press_o),
        .release_o  (release_o),
        .long_o     (long_o),
        .any_event_o(any_event_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] k,
                       input logic [3:0] p, input logic [3:0] r,
                       input logic [3:0] l);
        logic a;
        a = |(p | r | l);
        total++;
        assert (key_o === k) else begin
            bad++;
            $error("FAIL %s key_o got=%b exp=%b", tag, key_o, k);
        end
        total++;
        assert (press_o === p) else begin
            bad++;
            $error("FAIL %s press_o got=%b exp=%b", tag, press_o, p);
        end
        total++;
        assert (release_o === r) else begin
            bad++;
            $error("FAIL %s release_o got=%b exp=%b", tag, release_o, r);
        end
        total++;
        assert (long_o === l) else begin
            bad++;
            $error("FAIL %s long_o got=%b exp=%b", tag, long_o, l);
        end
        total++;
        assert (any_event_o === a) else begin
            bad++;
            $error("FAIL %s any_event_o got=%b exp=%b", tag, any_event_o, a);
        end
    endtask

    // n edges with no pulses expected and a steady debounced level
    task automatic quiet(input int n, input logic [3:0] k, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, k, 4'b0000, 4'b0000, 4'b0000);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        key_i   = 4'b0000;

        // reset state
        #1;
        chk("reset0", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();
        chk("reset1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset_n = 1'b1;
        quiet(3, 4'b0000, "idle");

        // clean press on ch0: key_o/press 8 edges after first sample
        key_i = 4'b0001;
        quiet(7, 4'b0000, "p0_wait");
        tick();
        chk("p0_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        quiet(1, 4'b0001, "p0_after");
        key_i = 4'b0000;
        quiet(7, 4'b0001, "p0_rwait");
        tick();
        chk("p0_rel", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        quiet(2, 4'b0000, "p0_idle");

        // bounce on ch1: 3-cycle high pulses never qualify
        key_i = 4'b0010;
        quiet(3, 4'b0000, "b1_hi");
        key_i = 4'b0000;
        quiet(2, 4'b0000, "b1_lo");
        key_i = 4'b0010;
        quiet(3, 4'b0000, "b1_hi");
        key_i = 4'b0000;
        quiet(2, 4'b0000, "b1_lo");
        key_i = 4'b0010;
        quiet(7, 4'b0000, "b1_wait");
        tick();
        chk("b1_press", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        quiet(1, 4'b0010, "b1_after");
        key_i = 4'b0000;
        quiet(7, 4'b0010, "b1_rwait");
        tick();
        chk("b1_rel", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        quiet(2, 4'b0000, "b1_idle");

        // long press on ch2: key_i high for 30 cycles
        key_i = 4'b0100;
        quiet(7, 4'b0000, "l2_wait");
        tick();
        chk("l2_press", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        quiet(9, 4'b0100, "l2_hold");
        tick();
        chk("l2_long", 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        quiet(12, 4'b0100, "l2_nolong");
        key_i = 4'b0000;
        quiet(7, 4'b0100, "l2_rwait");
        tick();
        chk("l2_rel", 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        quiet(2, 4'b0000, "l2_idle");

        // short 2-cycle drop on ch3 during a held press
        key_i = 4'b1000;
        quiet(7, 4'b0000, "s3_wait");
        tick();
        chk("s3_press", 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        quiet(2, 4'b1000, "s3_hold");
        key_i = 4'b0000;
        quiet(2, 4'b1000, "s3_glitch");
        key_i = 4'b1000;
        quiet(5, 4'b1000, "s3_hold2");
        tick();
        chk("s3_long", 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        quiet(2, 4'b1000, "s3_after");
        key_i = 4'b0000;
        quiet(7, 4'b1000, "s3_rwait");
        tick();
        chk("s3_rel", 4'b0000, 4'b0000, 4'b1000, 4'b0000);
        quiet(2, 4'b0000, "s3_idle");

        // simultaneous press on all channels
        key_i = 4'b1111;
        quiet(7, 4'b0000, "all_wait");
        tick();
        chk("all_press", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        quiet(1, 4'b1111, "all_after");

        // reset mid-count: release in progress is aborted
        key_i = 4'b0000;
        quiet(3, 4'b1111, "rst_pre");
        reset_n = 1'b0;
        #1;
        chk("rst_now", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();
        chk("rst_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset_n = 1'b1;
        quiet(12, 4'b0000, "rst_post");

        // key held through reset deassertion acts as a fresh press
        reset_n = 1'b0;
        key_i   = 4'b0001;
        tick();
        tick();
        chk("hold_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset_n = 1'b1;
        quiet(7, 4'b0000, "hr_wait");
        tick();
        chk("hr_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        quiet(2, 4'b0001, "hr_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
